// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  // Transmit/receive frame sequencing states.
  typedef enum logic [2:0] {
    GUARD,
    IDLE,
    ARM,
    START,
    DATA,
    PAR,
    STOP1,
    STOP2
  } uart_state_e;

  // Number of bd8_rate ticks that make up one bit time.
  localparam int OVERSAMPLE = 8;

  // Parity-select strings; any other value means no parity bit.
  localparam string PARITY_ODD  = "ODD";
  localparam string PARITY_EVEN = "EVEN";

  // Parity bit for a byte: odd makes the total count of ones odd, even makes it even.
  function automatic logic parityBit(input logic [7:0] data, input logic oddSel);
    return oddSel ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2
// stop bits, one bit per 8 bd8_rate ticks, byte-level valid/ready handshake.
module uart_tx
  import uart_pkg::*;
#(
  parameter string PARITY    = "ODD",
  parameter int    STOP_BIT  = 1,
  parameter int    IDLE_BITS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bd8_rate,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam bit PAR_EN  = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
  localparam bit PAR_ODD = (PARITY == PARITY_ODD);

  localparam int TICKW = $clog2(OVERSAMPLE);
  localparam int BCW   = ($clog2(IDLE_BITS + 1) > 4) ? $clog2(IDLE_BITS + 1) : 4;

  localparam logic [TICKW-1:0] TICK_LAST  = TICKW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0]   GUARD_LAST = BCW'(IDLE_BITS - 1);
  localparam logic [BCW-1:0]   DATA_LAST  = BCW'(7);

  uart_state_e      state_q;
  logic [TICKW-1:0] tickCnt_q;
  logic [BCW-1:0]   bitCnt_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic             txd_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             bitEnd;

  // A bit time closes on the tick that wraps the tick counter from 7 to 0.
  assign bitEnd = bd8_rate && (tickCnt_q == TICK_LAST);

  // Tick counter: parked at zero while waiting so the start bit gets a full 8 ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tickCnt_q <= '0;
    end else if (bd8_rate) begin
      if (state_q == IDLE || state_q == ARM) begin
        tickCnt_q <= '0;
      end else begin
        tickCnt_q <= tickCnt_q + 1'b1;
      end
    end
  end

  // Bit counter: counts guard bit times after reset and data bits within a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitCnt_q <= '0;
    end else if (bitEnd) begin
      if (state_q == GUARD || state_q == DATA) begin
        bitCnt_q <= bitCnt_q + 1'b1;
      end else begin
        bitCnt_q <= '0;
      end
    end
  end

  // Frame sequencer with registered line and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GUARD;
      txd_q    <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        GUARD: begin
          txd_q <= 1'b1;
          if (bitEnd && bitCnt_q == GUARD_LAST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          txd_q <= 1'b1;
          if (tx_valid && ready_q) begin
            shift_q  <= tx_data;
            parity_q <= parityBit(tx_data, PAR_ODD);
            state_q  <= ARM;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ARM: begin
          if (bd8_rate) begin
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitCnt_q == DATA_LAST) begin
              if (PAR_EN) begin
                txd_q   <= parity_q;
                state_q <= PAR;
              end else begin
                txd_q   <= 1'b1;
                state_q <= STOP1;
              end
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
            end
          end
        end
        PAR: begin
          if (bitEnd) begin
            txd_q   <= 1'b1;
            state_q <= STOP1;
          end
        end
        STOP1: begin
          if (bitEnd) begin
            if (STOP_BIT == 2) begin
              state_q <= STOP2;
            end else begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        STOP2: begin
          if (bitEnd) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= GUARD;
          txd_q   <= 1'b1;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (odd/1 stop, none/2 stop, even/1 stop)
// share clock, reset and the 8x baud tick; each frame is compared bit by bit
// against a frame built from the framing rules.
module tb_uart_tx;

  localparam int GUARD_TICKS = 11 * 8;
  localparam int WAIT_LIMIT  = 5000;

  logic       clk = 1'b0;
  logic       rst;
  logic       bd8_rate;
  logic [7:0] tx_data;
  logic [2:0] txValid;
  wire  [2:0] txReadyV;
  wire  [2:0] txdV;
  wire  [2:0] busyV;
  wire  [2:0] doneV;

  int tickNum   = 0;
  int bdDiv     = 4;
  int bdCnt     = 0;
  bit bdPause   = 1'b0;
  int vecCount  = 0;
  int missCount = 0;

  // Per-instance framing: parity mode 0=none 1=odd 2=even, and stop bit count.
  int parMode[3]  = '{1, 0, 2};
  int stopBits[3] = '{1, 2, 1};

  uart_tx #(.PARITY("ODD"), .STOP_BIT(1), .IDLE_BITS(11)) dut0 (
    .clk(clk), .rst(rst), .bd8_rate(bd8_rate), .tx_data(tx_data), .tx_valid(txValid[0]),
    .tx_ready(txReadyV[0]), .txd(txdV[0]), .tx_busy(busyV[0]), .tx_done(doneV[0])
  );

  uart_tx #(.PARITY("NONE"), .STOP_BIT(2), .IDLE_BITS(11)) dut1 (
    .clk(clk), .rst(rst), .bd8_rate(bd8_rate), .tx_data(tx_data), .tx_valid(txValid[1]),
    .tx_ready(txReadyV[1]), .txd(txdV[1]), .tx_busy(busyV[1]), .tx_done(doneV[1])
  );

  uart_tx #(.PARITY("EVEN"), .STOP_BIT(1), .IDLE_BITS(11)) dut2 (
    .clk(clk), .rst(rst), .bd8_rate(bd8_rate), .tx_data(tx_data), .tx_valid(txValid[2]),
    .tx_ready(txReadyV[2]), .txd(txdV[2]), .tx_busy(busyV[2]), .tx_done(doneV[2])
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Baud tick generator: one pulse every bdDiv clocks, silenced while bdPause is set.
  initial begin
    bd8_rate = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bdCnt + 1 >= bdDiv) bdCnt = 0;
      else bdCnt++;
      bd8_rate = !bdPause && (bdCnt == 0);
    end
  end

  // Running count of tick edges, the time base for all expected timing.
  always @(posedge clk) begin
    if (bd8_rate) tickNum <= tickNum + 1;
  end

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  // Builds the expected serial frame for a byte and returns its length in bits.
  function automatic int modelFrame(input int data, input int pmode, input int stops, output bit [11:0] bits);
    int n;
    int ones;
    int b;
    n = 0;
    ones = 0;
    bits = '0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      b = (data >> i) & 1;
      ones += b;
      bits[n] = b[0];
      n++;
    end
    if (pmode == 1) begin
      bits[n] = (ones % 2 == 0);
      n++;
    end else if (pmode == 2) begin
      bits[n] = (ones % 2 == 1);
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      bits[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  // Waits out the post-reset guard on all instances and checks its length and line level.
  task automatic waitGuard();
    int t0;
    int c;
    bit txdHigh;
    int dones;
    t0 = tickNum;
    c = 0;
    txdHigh = 1'b1;
    dones = 0;
    while (txReadyV == 3'b000 && c < WAIT_LIMIT) begin
      if (txdV !== 3'b111) txdHigh = 1'b0;
      if (doneV !== 3'b000) dones++;
      @(negedge clk);
      c++;
    end
    checkOutput("guardTicks", tickNum - t0, GUARD_TICKS);
    checkOutput("guardReadyAll", txReadyV, 3'b111);
    checkOutput("guardTxdHigh", txdHigh, 1);
    checkOutput("guardNoDone", dones, 0);
    checkOutput("idleBusy", busyV, 3'b000);
  endtask

  // Offers one byte to an instance and checks the handshake on acceptance.
  task automatic applyStimulus(input int idx, input logic [7:0] data, input logic [7:0] laterData,
                               input bit keepValid, output int acceptTick);
    int c;
    c = 0;
    while (txReadyV[idx] !== 1'b1 && c < WAIT_LIMIT) begin
      @(negedge clk);
      c++;
    end
    checkOutput("readyWait", txReadyV[idx], 1);
    tx_data = data;
    txValid[idx] = 1'b1;
    @(negedge clk);
    acceptTick = tickNum;
    checkOutput("readyDrop", txReadyV[idx], 0);
    checkOutput("busyOnAccept", busyV[idx], 1);
    if (!keepValid) txValid[idx] = 1'b0;
    tx_data = laterData;
  endtask

  // Follows one frame on the line, sampling each bit mid-way; optionally resets mid-frame.
  task automatic checkFrame(input int idx, input logic [7:0] data, input int acceptTick,
                            input bit chained, input int resetAtBit, output int nextAccept);
    bit [11:0] expBits;
    int nBits;
    int startTick;
    int doneTick;
    int prevTick;
    int rel;
    int nextK;
    int c;
    bit prevTxd;
    bit doneSeen;
    nextAccept = 0;
    nBits = modelFrame(data, parMode[idx], stopBits[idx], expBits);
    c = 0;
    while (txdV[idx] !== 1'b0 && c < WAIT_LIMIT) begin
      @(negedge clk);
      c++;
    end
    checkOutput("startSeen", (c < WAIT_LIMIT), 1);
    if (c >= WAIT_LIMIT) return;
    startTick = tickNum;
    checkOutput("startOnNextTick", startTick - acceptTick, 1);
    prevTxd = 1'b0;
    prevTick = startTick;
    nextK = 0;
    doneSeen = 1'b0;
    doneTick = 0;
    c = 0;
    while (!doneSeen && c < 20000) begin
      rel = tickNum - startTick;
      if (txdV[idx] !== prevTxd) begin
        checkOutput("edgeOnTick", (tickNum != prevTick), 1);
        prevTxd = txdV[idx];
      end
      if (resetAtBit >= 0 && rel == 8 * resetAtBit + 2) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstTxd", txdV[idx], 1);
        checkOutput("rstBusy", busyV[idx], 1);
        checkOutput("rstNoDone", doneV[idx], 0);
        rst = 1'b0;
        waitGuard();
        return;
      end
      if (nextK < nBits && rel == 8 * nextK + 4) begin
        checkOutput($sformatf("bit%0d", nextK), txdV[idx], expBits[nextK]);
        if (nextK == 5) begin
          checkOutput("midBusy", busyV[idx], 1);
          checkOutput("midReady", txReadyV[idx], 0);
        end
        nextK++;
      end
      if (doneV[idx] === 1'b1) begin
        doneSeen = 1'b1;
        doneTick = tickNum;
      end else begin
        prevTick = tickNum;
        @(negedge clk);
        c++;
      end
    end
    checkOutput("doneSeen", doneSeen, 1);
    if (!doneSeen) return;
    checkOutput("frameTicks", doneTick - startTick, 8 * nBits);
    checkOutput("bitsSampled", nextK, nBits);
    checkOutput("readyAtDone", txReadyV[idx], 1);
    @(negedge clk);
    checkOutput("donePulse", doneV[idx], 0);
    checkOutput("idleTxd", txdV[idx], 1);
    if (chained) begin
      checkOutput("chainAccepted", txReadyV[idx], 0);
      checkOutput("chainBusy", busyV[idx], 1);
      nextAccept = tickNum;
      txValid[idx] = 1'b0;
    end else begin
      checkOutput("idleReady", txReadyV[idx], 1);
      checkOutput("idleNotBusy", busyV[idx], 0);
    end
  endtask

  // Main sequence: reset, directed frames, held-valid chaining, stalled ARM, random frames, mid-frame reset.
  initial begin
    int acc;
    int acc2;
    int dummy;
    int idx;
    logic [7:0] data;
    rst = 1'b1;
    txValid = 3'b000;
    tx_data = 8'h00;
    repeat (5) @(negedge clk);
    checkOutput("rstTxdAll", txdV, 3'b111);
    checkOutput("rstReadyAll", txReadyV, 3'b000);
    checkOutput("rstBusyAll", busyV, 3'b111);
    checkOutput("rstDoneAll", doneV, 3'b000);
    rst = 1'b0;
    waitGuard();

    applyStimulus(0, 8'hA5, 8'h3B, 1'b0, acc);
    checkFrame(0, 8'hA5, acc, 1'b0, -1, dummy);

    applyStimulus(1, 8'h00, 8'hFF, 1'b0, acc);
    checkFrame(1, 8'h00, acc, 1'b0, -1, dummy);

    applyStimulus(0, 8'h81, 8'h55, 1'b0, acc);
    checkFrame(0, 8'h81, acc, 1'b0, -1, dummy);

    applyStimulus(2, 8'h3C, 8'hFF, 1'b1, acc);
    checkFrame(2, 8'h3C, acc, 1'b1, -1, acc2);
    checkFrame(2, 8'hFF, acc2, 1'b0, -1, dummy);

    bdPause = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1, 8'hC3, 8'h00, 1'b0, acc);
    repeat (20) @(negedge clk);
    checkOutput("armTxd", txdV[1], 1);
    checkOutput("armBusy", busyV[1], 1);
    checkOutput("armReady", txReadyV[1], 0);
    bdPause = 1'b0;
    checkFrame(1, 8'hC3, acc, 1'b0, -1, dummy);

    for (int n = 0; n < 12; n++) begin
      bdDiv = $urandom_range(1, 5);
      idx = $urandom_range(0, 2);
      data = 8'($urandom);
      applyStimulus(idx, data, 8'($urandom), 1'b0, acc);
      checkFrame(idx, data, acc, 1'b0, -1, dummy);
    end

    bdDiv = 3;
    applyStimulus(0, 8'h5A, 8'hA5, 1'b0, acc);
    checkFrame(0, 8'h5A, acc, 1'b0, 4, dummy);

    bdDiv = 1;
    applyStimulus(0, 8'h96, 8'h00, 1'b0, acc);
    checkFrame(0, 8'h96, acc, 1'b0, -1, dummy);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
